// File: rtl/led_rgb_fader.sv
// led_rgb_fader: per-channel PWM dimmer that ramps each RGB channel linearly toward its on/off target.
// Optional LED_RGB_FADER_GAMMA_EN selects a squared duty curve with one extra duty pipeline register.
module led_rgb_fader #(
  parameter bit INVERSE_MODE = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        led_r_in,
  input  logic        led_g_in,
  input  logic        led_b_in,
  input  logic [7:0]  brightness_r,
  input  logic [7:0]  brightness_g,
  input  logic [7:0]  brightness_b,
  input  logic [15:0] fade_step_div,
  output logic [2:0]  fade_busy,
  output logic        LED_R,
  output logic        LED_G,
  output logic        LED_B
);

  typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_ON, ST_FALL} fade_state_t;

  logic [2:0]  r_on;
  logic [15:0] r_pre_cnt;
  logic [7:0]  r_pwm_cnt;
  logic        w_tick;
  logic [2:0]  w_led_in;
  logic [2:0]  w_led_out;
  logic [7:0]  w_bright [3];

  assign w_led_in    = {led_b_in, led_g_in, led_r_in};
  assign w_bright[0] = brightness_r;
  assign w_bright[1] = brightness_g;
  assign w_bright[2] = brightness_b;
  assign w_tick      = (r_pre_cnt == fade_step_div);

  assign LED_R = w_led_out[0];
  assign LED_G = w_led_out[1];
  assign LED_B = w_led_out[2];

  // A divider lowered below the running count lets the count wrap through 2^16 before the next tick.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_on      <= 3'b000;
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= 8'd0;
    end else begin
      r_on      <= w_led_in ^ {3{INVERSE_MODE}};
      r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
      r_pwm_cnt <= (r_pwm_cnt == 8'd254) ? 8'd0 : r_pwm_cnt + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [7:0]  w_tgt;
      logic [7:0]  r_level;
      logic [7:0]  w_duty;
      logic        w_active;
      logic        r_led;
      fade_state_t w_state;
      fade_state_t r_state;

      assign w_tgt = r_on[gi] ? w_bright[gi] : 8'd0;

      // Level steps use this cycle's compare, so a ramp stops exactly on target.
      always_comb begin
        w_state = ST_OFF;
        if (r_level < w_tgt) begin
          w_state = ST_RISE;
        end else if (r_level > w_tgt) begin
          w_state = ST_FALL;
        end else if (w_tgt != 8'd0) begin
          w_state = ST_ON;
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_level <= 8'd0;
          r_state <= ST_OFF;
        end else begin
          r_state <= w_state;
          if (w_tick) begin
            case (w_state)
              ST_RISE: r_level <= r_level + 8'd1;
              ST_FALL: r_level <= r_level - 8'd1;
              default: r_level <= r_level;
            endcase
          end
        end
      end

      assign fade_busy[gi] = (r_state == ST_RISE) || (r_state == ST_FALL);

`ifdef LED_RGB_FADER_GAMMA_EN
      logic [15:0] w_sq;
      logic [15:0] w_sq_rnd;
      logic [7:0]  r_duty;

      assign w_sq     = {8'd0, r_level} * {8'd0, r_level};
      assign w_sq_rnd = w_sq + 16'd255;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_duty <= 8'd0;
        end else begin
          r_duty <= 8'(w_sq_rnd >> 8);
        end
      end

      assign w_duty = r_duty;
`else
      assign w_duty = r_level;
`endif

      assign w_active = (r_pwm_cnt < w_duty);

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_led <= INVERSE_MODE;
        end else begin
          r_led <= w_active ^ INVERSE_MODE;
        end
      end

      assign w_led_out[gi] = r_led;
    end
  endgenerate

endmodule
